// File: rtl/aes_bridge_pkg.sv
// Shared types and constants for the AES I/O bridge: state encoding, word geometry
// and the word-index to bit-offset mapping (word 0 is the most-significant word).
package aes_bridge_pkg;

  localparam int WORD_W          = 32;
  localparam int WORDS_PER_KEY   = 4;
  localparam int WORDS_PER_BLOCK = 4;
  localparam int BLOCK_W         = WORD_W * WORDS_PER_BLOCK;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  function automatic int word_lsb(input logic [1:0] idx);
    return (WORDS_PER_BLOCK - 1 - int'(idx)) * WORD_W;
  endfunction

endpackage

// File: rtl/aes_word_serializer.sv
// Loads a 128-bit result and emits it as four 32-bit words, MS word first; first word
// valid the cycle after load. Word and index hold while m_valid && !m_ready.
module aes_word_serializer
  import aes_bridge_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [BLOCK_W-1:0] din,
  output logic [WORD_W-1:0]  m_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               last_xfer
);

  logic [BLOCK_W-1:0] result;
  logic [1:0]         idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result  <= '0;
      idx     <= '0;
      m_valid <= 1'b0;
    end else if (load) begin
      result  <= din;
      idx     <= '0;
      m_valid <= 1'b1;
    end else if (m_valid && m_ready) begin
      idx <= idx + 2'd1;
      if (idx == 2'd3) begin
        m_valid <= 1'b0;
      end
    end
  end

  assign m_data    = result[word_lsb(idx) +: WORD_W];
  assign last_xfer = m_valid && m_ready && (idx == 2'd3);

endmodule

// File: rtl/aes_io_bridge.sv
// Streams key+plaintext words into an AES core and the ciphertext back out; minimum
// latency 8 load + core + 1 capture + 4 drain cycles. s_ready only in LOAD, m_valid only in DRAIN.
module aes_io_bridge
  import aes_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               AES_clk,
  input  logic               AES_rst_n,
  input  logic [WORD_W-1:0]  s_data,
  input  logic               s_valid,
  output logic               s_ready,
  output logic [WORD_W-1:0]  m_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               aes_en,
  output logic [BLOCK_W-1:0] aes_key_in,
  output logic [BLOCK_W-1:0] aes_data_in,
  input  logic [BLOCK_W-1:0] aes_data_out,
  input  logic               aes_data_out_valid,
  output logic               busy,
  output logic               timeout_err
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

  state_t        state;
  logic [2:0]    wcnt;
  logic [TW-1:0] tcnt;
  logic          s_fire;
  logic          capture;
  logic          last_xfer;

  assign s_fire  = s_valid && s_ready;
  assign capture = (state == RUN) && aes_data_out_valid;
  assign busy    = (state != LOAD);

  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) begin
      state       <= LOAD;
      wcnt        <= '0;
      tcnt        <= '0;
      aes_en      <= 1'b0;
      aes_key_in  <= '0;
      aes_data_in <= '0;
      s_ready     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        LOAD: begin
          s_ready <= 1'b1;
          if (s_fire) begin
            if (!wcnt[2]) begin
              aes_key_in[word_lsb(wcnt[1:0]) +: WORD_W] <= s_data;
            end else begin
              aes_data_in[word_lsb(wcnt[1:0]) +: WORD_W] <= s_data;
            end
            // wcnt wraps 7 -> 0, so the counter is already clear for the next block
            wcnt <= wcnt + 3'd1;
            if (wcnt == 3'd7) begin
              state   <= RUN;
              aes_en  <= 1'b1;
              s_ready <= 1'b0;
              tcnt    <= '0;
            end
          end
        end
        RUN: begin
          // a result arriving on the final timeout cycle still wins
          if (aes_data_out_valid) begin
            state  <= DRAIN;
            aes_en <= 1'b0;
          end else if (tcnt == TMAX) begin
            state       <= LOAD;
            aes_en      <= 1'b0;
            timeout_err <= 1'b1;
            s_ready     <= 1'b1;
            wcnt        <= '0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        DRAIN: begin
          if (last_xfer) begin
            state   <= LOAD;
            s_ready <= 1'b1;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  aes_word_serializer u_ser (
    .clk       (AES_clk),
    .rst_n     (AES_rst_n),
    .load      (capture),
    .din       (aes_data_out),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .last_xfer (last_xfer)
  );

endmodule

// File: tb/tb_aes_io_bridge.sv
// Bench for aes_io_bridge with a behavioural AES core stub (programmable strobe latency,
// FIPS-197 vector answered exactly, other blocks by a simple keyed mixing function).
module tb_aes_io_bridge;

  localparam int TMO = 64;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [31:0]  s_data = '0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [31:0]  m_data;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic         aes_en;
  logic [127:0] aes_key_in;
  logic [127:0] aes_data_in;
  logic [127:0] aes_data_out = '0;
  logic         aes_data_out_valid = 1'b0;
  logic         busy;
  logic         timeout_err;

  int n_cmp = 0;
  int n_bad = 0;

  int           stub_lat = 0;
  logic         junk_strobe = 1'b0;
  logic         allow_to = 1'b0;
  logic [127:0] exp_key = '0;
  logic [127:0] exp_pt  = '0;

  aes_io_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
    .AES_clk            (clk),
    .AES_rst_n          (rst_n),
    .s_data             (s_data),
    .s_valid            (s_valid),
    .s_ready            (s_ready),
    .m_data             (m_data),
    .m_valid            (m_valid),
    .m_ready            (m_ready),
    .aes_en             (aes_en),
    .aes_key_in         (aes_key_in),
    .aes_data_in        (aes_data_in),
    .aes_data_out       (aes_data_out),
    .aes_data_out_valid (aes_data_out_valid),
    .busy               (busy),
    .timeout_err        (timeout_err)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] p);
    if (k == FIPS_KEY && p == FIPS_PT) return FIPS_CT;
    return {p[95:0], p[127:96]} ^ k ^ 128'h5a5a_0f0f_3c3c_a5a5_1234_5678_9abc_def0;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Core stub: strobes on the stub_lat-th cycle of aes_en (0 = never answers)
  int en_cnt = 0;
  always @(negedge clk) begin
    #1;
    if (aes_en) en_cnt++;
    else en_cnt = 0;
    aes_data_out_valid = junk_strobe || (aes_en && stub_lat != 0 && en_cnt == stub_lat);
    aes_data_out = junk_strobe ? ~core_fn(aes_key_in, aes_data_in) : core_fn(aes_key_in, aes_data_in);
  end

  // Protocol invariants, sampled well after each rising edge
  logic        prev_vld = 1'b0;
  logic [31:0] prev_dat = '0;
  logic        en_prev = 1'b0;
  int          low_run = 100;
  always @(posedge clk) begin
    #2;
    if (rst_n) begin
      chk("s_ready_and_m_valid", {1'b0, s_ready && m_valid}, 0);
      if (prev_vld && !m_ready) begin
        chk("stall_m_valid", {1'b0, m_valid}, 1);
        chk("stall_m_data", {96'b0, m_data}, {96'b0, prev_dat});
      end
      if (aes_en) begin
        chk("run_key_stable", aes_key_in, exp_key);
        chk("run_data_stable", aes_data_in, exp_pt);
      end
      if (!allow_to) chk("spurious_timeout_err", {1'b0, timeout_err}, 0);
    end
    if (aes_en && !en_prev) chk("aes_en_low_gap>=4", {1'b0, low_run >= 4}, 1);
    low_run  = aes_en ? 0 : low_run + 1;
    en_prev  = aes_en;
    prev_vld = m_valid;
    prev_dat = m_data;
  end

  task automatic send_block(input logic [127:0] k, input logic [127:0] p, input bit toggle);
    logic [31:0] w [8];
    int  i;
    int  g;
    bit  ph;
    bit  acc;
    for (int j = 0; j < 4; j++) begin
      w[j]     = k[127 - 32*j -: 32];
      w[4 + j] = p[127 - 32*j -: 32];
    end
    exp_key = k;
    exp_pt  = p;
    i = 0; g = 0; ph = 1'b0;
    while (i < 8 && g < 100) begin
      s_valid = toggle ? ph : 1'b1;
      ph      = ~ph;
      s_data  = w[i];
      acc     = s_valid && s_ready;
      @(negedge clk);
      if (acc) i++;
      g++;
    end
    s_valid = 1'b0;
    if (i != 8) chk("send_words_accepted", i, 8);
  endtask

  task automatic recv_block(input logic [127:0] ct, input bit stall);
    int g;
    for (int w = 0; w < 4; w++) begin
      g = 0;
      while (!m_valid && g < 300) begin
        @(negedge clk);
        g++;
      end
      if (!m_valid) begin
        chk("m_valid_wait_expired", 0, 1);
        return;
      end
      chk($sformatf("m_data_word%0d", w), {96'b0, m_data}, {96'b0, ct[127 - 32*w -: 32]});
      if (stall) begin
        m_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk("stalled_m_data", {96'b0, m_data}, {96'b0, ct[127 - 32*w -: 32]});
          chk("aes_en_in_drain", {1'b0, aes_en}, 0);
        end
      end
      m_ready = 1'b1;
      @(negedge clk);
      m_ready = 1'b0;
    end
    chk("m_valid_after_last", {1'b0, m_valid}, 0);
    chk("s_ready_after_last", {1'b0, s_ready}, 1);
  endtask

  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
    int           lat;
    bit           stall;
    bit           toggle;
    bit           exp_to;
  } vec_t;

  function automatic vec_t mk(input logic [127:0] k, input logic [127:0] p, input int lat,
                              input bit stall, input bit toggle);
    vec_t v;
    v.key = k; v.pt = p; v.lat = lat; v.stall = stall; v.toggle = toggle;
    v.ct = core_fn(k, p);
    v.exp_to = (lat == 0) || (lat > TMO);
    return v;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic run_vec(input vec_t v);
    int g;
    stub_lat = v.lat;
    allow_to = v.exp_to;
    send_block(v.key, v.pt, v.toggle);
    if (v.exp_to) begin
      g = 0;
      while (!timeout_err && g < 200) begin
        @(negedge clk);
        g++;
      end
      chk("timeout_err_pulse", {1'b0, timeout_err}, 1);
      @(negedge clk);
      chk("s_ready_after_abort", {1'b0, s_ready}, 1);
      allow_to = 1'b0;
    end else begin
      recv_block(v.ct, v.stall);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    int   t;
    int   seen;
    logic [127:0] k;

    tbl.push_back('{FIPS_KEY, FIPS_PT, FIPS_CT, 10, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{FIPS_KEY, FIPS_PT, FIPS_CT, 20, 1'b1, 1'b0, 1'b0});
    tbl.push_back(mk(128'haa2bdb40bff6a5e8caa9ba3ebc1e2acc, 128'h000000c9_00000000_00000000_00000000, 6, 1'b0, 1'b1));
    tbl.push_back(mk(rnd128(), rnd128(), 1,  1'b0, 1'b0));
    tbl.push_back(mk(rnd128(), rnd128(), 63, 1'b1, 1'b0));
    tbl.push_back(mk(rnd128(), rnd128(), 64, 1'b0, 1'b0));
    tbl.push_back(mk(rnd128(), rnd128(), 65, 1'b0, 1'b1));
    for (int i = 0; i < 6; i++)
      tbl.push_back(mk(rnd128(), rnd128(), int'($urandom_range(1, 80)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))));

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_s_ready", {1'b0, s_ready}, 0);
    chk("rst_m_valid", {1'b0, m_valid}, 0);
    chk("rst_aes_en", {1'b0, aes_en}, 0);
    chk("rst_key", aes_key_in, 0);
    chk("rst_data", aes_data_in, 0);
    chk("rst_busy", {1'b0, busy}, 0);
    chk("rst_timeout_err", {1'b0, timeout_err}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_s_ready", {1'b0, s_ready}, 1);

    // Result strobe while idle in LOAD is ignored
    junk_strobe = 1'b1;
    @(negedge clk);
    junk_strobe = 1'b0;
    @(negedge clk);
    chk("load_strobe_busy", {1'b0, busy}, 0);
    chk("load_strobe_m_valid", {1'b0, m_valid}, 0);

    foreach (tbl[i]) run_vec(tbl[i]);

    // Timeout exactly TMO cycles after aes_en rises
    stub_lat = 0;
    allow_to = 1'b1;
    send_block(rnd128(), rnd128(), 1'b0);
    chk("to_aes_en_high", {1'b0, aes_en}, 1);
    t = 0;
    while (!timeout_err && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("timeout_latency", t, TMO);
    chk("to_aes_en_low", {1'b0, aes_en}, 0);
    @(negedge clk);
    chk("to_s_ready_next", {1'b0, s_ready}, 1);
    chk("to_pulse_one_cycle", {1'b0, timeout_err}, 0);
    allow_to = 1'b0;

    // Strobe during DRAIN must not disturb the pending result
    stub_lat = 3;
    send_block(FIPS_KEY, FIPS_PT, 1'b0);
    t = 0;
    while (!m_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    junk_strobe = 1'b1;
    @(negedge clk);
    junk_strobe = 1'b0;
    recv_block(FIPS_CT, 1'b0);

    // Reset mid-RUN discards the block; a following block is unaffected
    stub_lat = 0;
    send_block(FIPS_KEY, FIPS_PT, 1'b0);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrun_rst_aes_en", {1'b0, aes_en}, 0);
    chk("midrun_rst_key", aes_key_in, 0);
    chk("midrun_rst_data", aes_data_in, 0);
    chk("midrun_rst_busy", {1'b0, busy}, 0);
    chk("midrun_rst_m_data", {96'b0, m_data}, 0);
    chk("midrun_rst_s_ready", {1'b0, s_ready}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrun_release_s_ready", {1'b0, s_ready}, 1);
    run_vec('{FIPS_KEY, FIPS_PT, FIPS_CT, 15, 1'b0, 1'b0, 1'b0});

    // Reset mid-DRAIN leaves no partial output
    stub_lat = 4;
    k = rnd128();
    send_block(k, FIPS_PT, 1'b0);
    t = 0;
    while (!m_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    rst_n = 1'b0;
    #1;
    chk("middrain_rst_m_valid", {1'b0, m_valid}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (m_valid) seen++;
    end
    chk("middrain_no_output", seen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
